pc_lut_prog: RTL and testbench

Programmable branch-target table for the fetch stage: a writable, parametrised replacement for the fixed branch-target lookup. Entries are loaded at run time through a valid/ready write port, each tagged absolute or PC-relative. A registered lookup returns the resolved next PC one cycle later. After reset, a sweep invalidates every entry before the table accepts writes.

---
 rtl/pc_lut_prog_if.sv | 29 ++
 rtl/pc_lut_prog.sv | 111 +++++++++++
 tb/tb_pc_lut_prog.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_lut_prog_if.sv
// Bus bundle for the programmable branch-target table: the write port, the lookup port and status.
// The master side is the fetch/loader logic and the slave side is the table itself.
interface pc_lut_prog_if #(
   parameter int D = 12,
   parameter int A = 5
);
   logic         wr_valid;
   logic         wr_ready;
   logic [A-1:0] wr_addr;
   logic [D-1:0] wr_target;
   logic         wr_rel;
   logic         lk_valid;
   logic [A-1:0] lk_addr;
   logic [D-1:0] pc;
   logic         lk_done;
   logic         lk_hit;
   logic [D-1:0] next_pc;
   logic         busy;

   modport master (
      output wr_valid, wr_addr, wr_target, wr_rel, lk_valid, lk_addr, pc,
      input  wr_ready, lk_done, lk_hit, next_pc, busy
   );

   modport slave (
      input  wr_valid, wr_addr, wr_target, wr_rel, lk_valid, lk_addr, pc,
      output wr_ready, lk_done, lk_hit, next_pc, busy
   );
endinterface

// File: rtl/pc_lut_prog.sv
// Programmable branch-target table with a post-reset invalidation sweep and a 1-cycle registered lookup.
// Define PC_LUT_WRITE_FWD_EN to forward a same-cycle write to a lookup of the same address.
module pc_lut_prog #(
   parameter int D = 12,
   parameter int A = 5
) (
   input  logic         clk,
   input  logic         reset,
   pc_lut_prog_if.slave bus
);
   localparam int DEPTH = 2**A;

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [A-1:0]     r_idx;
   logic [A-1:0]     w_idx_next;
   logic [DEPTH-1:0] r_valid;
   logic [D:0]       r_mem [DEPTH];
   logic             r_lk_done;
   logic             r_lk_hit;
   logic [D-1:0]     r_next_pc;

   logic             w_wr_acc;
   logic             w_ent_valid;
   logic             w_ent_rel;
   logic [D-1:0]     w_ent_tgt;
   logic             w_hit;
   logic [D-1:0]     w_npc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_CLEAR;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      if (r_state == S_CLEAR) begin
         w_idx_next = r_idx + 1'b1;
         if (&r_idx) begin
            w_state_next = S_RUN;
         end
      end
   end

   assign bus.busy     = (r_state == S_CLEAR);
   assign bus.wr_ready = (r_state == S_RUN);
   assign w_wr_acc     = bus.wr_valid && bus.wr_ready && !reset;

   // Valid bits are flops so the sweep can clear one per cycle while the payload lives in LUT RAM.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
         always_ff @(posedge clk) begin
            if (r_state == S_CLEAR && r_idx == A'(gi)) begin
               r_valid[gi] <= 1'b0;
            end else if (w_wr_acc && bus.wr_addr == A'(gi)) begin
               r_valid[gi] <= 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[bus.wr_addr] <= {bus.wr_rel, bus.wr_target};
      end
   end

   always_comb begin
      w_ent_valid              = r_valid[bus.lk_addr];
      {w_ent_rel, w_ent_tgt}   = r_mem[bus.lk_addr];
`ifdef PC_LUT_WRITE_FWD_EN
      if (w_wr_acc && bus.wr_addr == bus.lk_addr) begin
         w_ent_valid = 1'b1;
         w_ent_rel   = bus.wr_rel;
         w_ent_tgt   = bus.wr_target;
      end
`endif
      // Lookups during the sweep always miss, whatever the stale valid bit says.
      w_hit = (r_state == S_RUN) && w_ent_valid;
      w_npc = bus.pc;
      if (w_hit) begin
         w_npc = w_ent_rel ? (bus.pc + w_ent_tgt) : w_ent_tgt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lk_done <= 1'b0;
         r_lk_hit  <= 1'b0;
         r_next_pc <= '0;
      end else begin
         r_lk_done <= bus.lk_valid;
         if (bus.lk_valid) begin
            r_lk_hit  <= w_hit;
            r_next_pc <= w_npc;
         end
      end
   end

   assign bus.lk_done = r_lk_done;
   assign bus.lk_hit  = r_lk_hit;
   assign bus.next_pc = r_next_pc;
endmodule

// File: tb/tb_pc_lut_prog.sv
// Self-checking bench for pc_lut_prog: directed scenarios plus randomized traffic against a table model.
// Build with PC_LUT_WRITE_FWD_EN defined to check the forwarding variant.
module tb_pc_lut_prog;
   localparam int D     = 12;
   localparam int A     = 5;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pc_lut_prog_if #(.D(D), .A(A)) bus ();

   pc_lut_prog #(.D(D), .A(A)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: table contents plus a countdown of remaining sweep cycles.
   bit           m_run  = 1'b0;
   int           m_left = DEPTH;
   bit           m_valid [DEPTH];
   logic [D-1:0] m_tgt   [DEPTH];
   bit           m_rel   [DEPTH];
   bit           e_done  = 1'b0;
   bit           e_hit   = 1'b0;
   logic [D-1:0] e_npc   = '0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input bit wv, input int wa, input int wt, input bit wr,
                        input bit lv, input int la, input int p);
      bus.wr_valid  = wv;
      bus.wr_addr   = A'(wa);
      bus.wr_target = D'(wt);
      bus.wr_rel    = wr;
      bus.lk_valid  = lv;
      bus.lk_addr   = A'(la);
      bus.pc        = D'(p);
   endtask

   // Advance one clock, update the model for that edge, then compare every output.
   task automatic step();
      bit           acc;
      bit           v;
      bit           r;
      logic [D-1:0] t;
      @(posedge clk);
      if (reset) begin
         m_run  = 1'b0;
         m_left = DEPTH;
         e_done = 1'b0;
         e_hit  = 1'b0;
         e_npc  = '0;
         for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      end else begin
         acc = bus.wr_valid && m_run;
         if (bus.lk_valid) begin
            e_done = 1'b1;
            v = m_valid[bus.lk_addr];
            r = m_rel[bus.lk_addr];
            t = m_tgt[bus.lk_addr];
`ifdef PC_LUT_WRITE_FWD_EN
            if (acc && bus.wr_addr == bus.lk_addr) begin
               v = 1'b1;
               r = bus.wr_rel;
               t = bus.wr_target;
            end
`endif
            if (m_run && v) begin
               e_hit = 1'b1;
               e_npc = r ? D'(int'(bus.pc) + int'(t)) : t;
            end else begin
               e_hit = 1'b0;
               e_npc = bus.pc;
            end
         end else begin
            e_done = 1'b0;
         end
         if (acc) begin
            m_valid[bus.wr_addr] = 1'b1;
            m_tgt[bus.wr_addr]   = bus.wr_target;
            m_rel[bus.wr_addr]   = bus.wr_rel;
         end
         if (!m_run) begin
            m_left--;
            if (m_left == 0) m_run = 1'b1;
         end
      end
      #1;
      check_val("lk_done", 32'(bus.lk_done), 32'(e_done));
      check_val("lk_hit", 32'(bus.lk_hit), 32'(e_hit));
      check_val("next_pc", 32'(bus.next_pc), 32'(e_npc));
      check_val("busy", 32'(bus.busy), 32'(!m_run));
      check_val("wr_ready", 32'(bus.wr_ready), 32'(m_run));
   endtask

   // Count busy cycles after reset release (bounded), optionally probing addr 0 in the first one.
   task automatic sweep_count(input bit probe);
      int busy_cycles = 0;
      for (int k = 0; k < 100; k++) begin
         if (!bus.busy) break;
         busy_cycles++;
         check_val("ready_in_sweep", 32'(bus.wr_ready), 32'd0);
         if (probe && k == 0) drive(1'b0, 0, 0, 1'b0, 1'b1, 0, 123);
         else drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
         step();
         if (probe && k == 0) begin
            check_val("sweep_lk_hit", 32'(bus.lk_hit), 32'd0);
            check_val("sweep_lk_pc", 32'(bus.next_pc), 32'd123);
         end
      end
      check_val("sweep_len", 32'(busy_cycles), 32'd32);
      check_val("ready_after_sweep", 32'(bus.wr_ready), 32'd1);
   endtask

   task automatic write_entry(input int wa, input int wt, input bit wr);
      drive(1'b1, wa, wt, wr, 1'b0, 0, 0);
      step();
   endtask

   task automatic lookup(input int la, input int p);
      drive(1'b0, 0, 0, 1'b0, 1'b1, la, p);
      step();
   endtask

   initial begin
      int exp_fwd;
      reset = 1'b1;
      drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
      step();
      step();
      check_val("rst_busy", 32'(bus.busy), 32'd1);
      check_val("rst_next_pc", 32'(bus.next_pc), 32'd0);
      reset = 1'b0;
      sweep_count(1'b1);

      write_entry(4, 7, 1'b0);
      lookup(4, 100);
      check_val("abs_done", 32'(bus.lk_done), 32'd1);
      check_val("abs_hit", 32'(bus.lk_hit), 32'd1);
      check_val("abs_pc", 32'(bus.next_pc), 32'd7);

      write_entry(10, 'hF21, 1'b1);
      lookup(10, 300);
      check_val("rel_hit", 32'(bus.lk_hit), 32'd1);
      check_val("rel_pc", 32'(bus.next_pc), 32'd77);

      write_entry(11, 'h010, 1'b1);
      lookup(11, 'hFF8);
      check_val("wrap_pc", 32'(bus.next_pc), 32'h008);

      lookup(20, 55);
      check_val("miss_hit", 32'(bus.lk_hit), 32'd0);
      check_val("miss_pc", 32'(bus.next_pc), 32'd55);

      write_entry(3, 5, 1'b0);
      drive(1'b1, 3, 9, 1'b0, 1'b1, 3, 0);
      step();
`ifdef PC_LUT_WRITE_FWD_EN
      exp_fwd = 9;
`else
      exp_fwd = 5;
`endif
      check_val("fwd_same_cycle", 32'(bus.next_pc), 32'(exp_fwd));
      lookup(3, 0);
      check_val("fwd_next_cycle", 32'(bus.next_pc), 32'd9);

      write_entry(4, 44, 1'b0);
      reset = 1'b1;
      drive(1'b0, 0, 0, 1'b0, 1'b1, 4, 1);
      step();
      reset = 1'b0;
      check_val("rst_mid_done", 32'(bus.lk_done), 32'd0);
      sweep_count(1'b0);
      lookup(4, 66);
      check_val("rst_mid_hit", 32'(bus.lk_hit), 32'd0);
      check_val("rst_mid_pc", 32'(bus.next_pc), 32'd66);

      // Randomized traffic with a narrow address range to provoke same-address collisions.
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 149) == 0);
         drive(($urandom_range(0, 1) == 1), $urandom_range(0, 7), $urandom, $urandom_range(0, 1) == 1,
               ($urandom_range(0, 9) < 7), $urandom_range(0, 7), $urandom);
         step();
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
